// File: rtl/abro_input_conditioner.sv
// Synchronizes and debounces the three ABRO push-buttons and produces
// one-cycle rising-edge pulses for the A/B inputs and the restart request.
module abro_input_conditioner #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic r_raw,
    output logic A,
    output logic B,
    output logic a_rise,
    output logic b_rise,
    output logic r_pulse
);

    localparam int         NUM_CH = 3;
    localparam logic [7:0] LIMIT  = 8'(DEBOUNCE - 1);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] r_s1;
    logic [NUM_CH-1:0] r_s2;
    logic [NUM_CH-1:0] r_lvl;
    logic [NUM_CH-1:0] r_rise;
    logic [7:0]        r_cnt [NUM_CH];

    // Channel order: bit 0 = a, bit 1 = b, bit 2 = r.
    assign w_raw = {r_raw, b_raw, a_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_lvl  <= '0;
            r_rise <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_rise[i] <= 1'b0;
                if (r_s2[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= LIMIT) begin
                    // Rise is registered together with the level so both appear in the same cycle.
                    r_lvl[i]  <= r_s2[i];
                    r_cnt[i]  <= '0;
                    r_rise[i] <= r_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign A       = r_lvl[0];
    assign B       = r_lvl[1];
    assign a_rise  = r_rise[0];
    assign b_rise  = r_rise[1];
    assign r_pulse = r_rise[2];

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Checks two conditioner instances (DEBOUNCE=4 and DEBOUNCE=1) against a
// window-based reference model, a vector table and hand-written corner cases.
module tb_abro_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic aRaw;
    logic bRaw;
    logic rRaw;
    logic outA      [2];
    logic outB      [2];
    logic outARise  [2];
    logic outBRise  [2];
    logic outRPulse [2];

    int errors = 0;
    int checks = 0;
    int dVal [2] = '{4, 1};

    bit       mD1   [2][3];
    bit       mD2   [2][3];
    bit       mLvl  [2][3];
    bit       mRise [2][3];
    bit [7:0] mHist [2][3];

    typedef struct {
        bit rst, a, b, r;
        bit eA, eB, eAR, eBR, eRP;
    } vecT;

    vecT vecs [$];

    always #5 clk = ~clk;

    abro_input_conditioner #(.DEBOUNCE(4)) dut4 (
        .clk(clk), .reset(reset), .a_raw(aRaw), .b_raw(bRaw), .r_raw(rRaw),
        .A(outA[0]), .B(outB[0]), .a_rise(outARise[0]), .b_rise(outBRise[0]),
        .r_pulse(outRPulse[0])
    );

    abro_input_conditioner #(.DEBOUNCE(1)) dut1 (
        .clk(clk), .reset(reset), .a_raw(aRaw), .b_raw(bRaw), .r_raw(rRaw),
        .A(outA[1]), .B(outB[1]), .a_rise(outARise[1]), .b_rise(outBRise[1]),
        .r_pulse(outRPulse[1])
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference: a level flips once the synchronized input (raw delayed two
    // edges) has disagreed with it on each of the last DEBOUNCE edges.
    task automatic modelStep();
        bit rawIn [3];
        bit cmp;
        bit allDiff;
        rawIn[0] = aRaw;
        rawIn[1] = bRaw;
        rawIn[2] = rRaw;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                if (reset) begin
                    mD1[d][c]   = 1'b0;
                    mD2[d][c]   = 1'b0;
                    mHist[d][c] = '0;
                    mLvl[d][c]  = 1'b0;
                    mRise[d][c] = 1'b0;
                end else begin
                    cmp         = mD2[d][c];
                    mD2[d][c]   = mD1[d][c];
                    mD1[d][c]   = rawIn[c];
                    mHist[d][c] = {mHist[d][c][6:0], cmp};
                    allDiff     = 1'b1;
                    for (int k = 0; k < dVal[d]; k++) begin
                        if (mHist[d][c][k] == mLvl[d][c]) allDiff = 1'b0;
                    end
                    mRise[d][c] = 1'b0;
                    if (allDiff) begin
                        mLvl[d][c]  = ~mLvl[d][c];
                        mRise[d][c] = mLvl[d][c];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("model D%0d A", dVal[d]),       outA[d],      mLvl[d][0]);
            checkOutput($sformatf("model D%0d B", dVal[d]),       outB[d],      mLvl[d][1]);
            checkOutput($sformatf("model D%0d a_rise", dVal[d]),  outARise[d],  mRise[d][0]);
            checkOutput($sformatf("model D%0d b_rise", dVal[d]),  outBRise[d],  mRise[d][1]);
            checkOutput($sformatf("model D%0d r_pulse", dVal[d]), outRPulse[d], mRise[d][2]);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit a, input bit b, input bit r);
        reset = rst;
        aRaw  = a;
        bRaw  = b;
        rRaw  = r;
        tick();
    endtask

    task automatic resetAll();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
    endtask

    function automatic vecT mk(input bit rst, a, b, r, eA, eB, eAR, eBR, eRP);
        vecT v;
        v.rst = rst; v.a = a; v.b = b; v.r = r;
        v.eA = eA; v.eB = eB; v.eAR = eAR; v.eBR = eBR; v.eRP = eRP;
        return v;
    endfunction

    initial begin
        int highCnt;
        int riseCnt;

        reset = 1'b1;
        aRaw  = 1'b0;
        bRaw  = 1'b0;
        rRaw  = 1'b0;

        // Vector table for DEBOUNCE=4: reset with buttons held, release, then falls.
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, 1, 1));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].r);
            checkOutput($sformatf("vec%0d A", i),       outA[0],      vecs[i].eA);
            checkOutput($sformatf("vec%0d B", i),       outB[0],      vecs[i].eB);
            checkOutput($sformatf("vec%0d a_rise", i),  outARise[0],  vecs[i].eAR);
            checkOutput($sformatf("vec%0d b_rise", i),  outBRise[0],  vecs[i].eBR);
            checkOutput($sformatf("vec%0d r_pulse", i), outRPulse[0], vecs[i].eRP);
        end

        // Single a rise held long: one pulse, fixed latency for both instances.
        resetAll();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("hold k%0d A4", k),      outA[0],     k >= 5);
            checkOutput($sformatf("hold k%0d a_rise4", k), outARise[0], k == 5);
            checkOutput($sformatf("hold k%0d B4", k),      outB[0],     1'b0);
            checkOutput($sformatf("hold k%0d b_rise4", k), outBRise[0], 1'b0);
            checkOutput($sformatf("hold k%0d A1", k),      outA[1],     k >= 2);
            checkOutput($sformatf("hold k%0d a_rise1", k), outARise[1], k == 2);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("fall k%0d A1", k),      outA[1],     k < 2);
            checkOutput($sformatf("fall k%0d a_rise1", k), outARise[1], 1'b0);
        end

        // b glitches of 3 and 4 cycles.
        resetAll();
        highCnt = 0;
        riseCnt = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(0, 0, k < 3, 0);
            highCnt += int'(outB[0]);
            riseCnt += int'(outBRise[0]);
        end
        checkCount("glitch3 B high cycles", highCnt, 0);
        checkCount("glitch3 b_rise count", riseCnt, 0);
        highCnt = 0;
        riseCnt = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, k < 4, 0);
            highCnt += int'(outB[0]);
            riseCnt += int'(outBRise[0]);
        end
        checkCount("glitch4 B high cycles", highCnt, 4);
        checkCount("glitch4 b_rise count", riseCnt, 1);

        // a and r rising together pulse in the same cycle.
        resetAll();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 0, 1);
            checkOutput($sformatf("sim k%0d a_rise", k),  outARise[0],  k == 5);
            checkOutput($sformatf("sim k%0d r_pulse", k), outRPulse[0], k == 5);
        end

        // Reset one cycle in the middle of a debounce restarts the latency.
        resetAll();
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("midrst A", outA[0], 1'b0);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("midrst j%0d A4", j),      outA[0],     j >= 5);
            checkOutput($sformatf("midrst j%0d a_rise4", j), outARise[0], j == 5);
            checkOutput($sformatf("midrst j%0d a_rise1", j), outARise[1], j == 2);
        end

        // Randomized inputs with occasional reset, checked by the model in tick().
        resetAll();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          ($urandom_range(0, 5) == 0) ? ~aRaw : aRaw,
                          ($urandom_range(0, 5) == 0) ? ~bRaw : bRaw,
                          ($urandom_range(0, 5) == 0) ? ~rRaw : rRaw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
